// File: rtl/imem_pkg.sv
// imem_pkg: shared states and sizing defaults for the instruction-memory loader.
package imem_pkg;
  localparam int DEPTH_DEF = 32;
  localparam int AW_DEF = 8;
  localparam int HDR_BYTES = 2;
  localparam int WORD_BYTES = 4;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR} state_t;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: DEPTH x 32 instruction RAM, sync write, async read, sync clear on reset.
module imem_ram #(
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [31:0]                wdata,
  input  logic [31:0]                addr,
  output logic [31:0]                rdata
);
  localparam int IW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic unused;
  assign unused = ^addr[1:0];
  // Whole word index is range-checked so aliasing addresses above the array read 0.
  assign rdata = (addr[31:2] < 30'(DEPTH)) ? mem[addr[IW+1:2]] : 32'h0;
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    else if (we) mem[waddr] <= wdata;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader filling the fetch-stage instruction RAM.
module imem_loader import imem_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  input  logic [31:0]   addr,
  output logic [31:0]   data,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] words_loaded
);
  state_t state, nxt;
  logic [15:0] n, n_new;
  logic [AW-1:0] ptr;
  logic [1:0] cnt;
  logic [31:0] asm_r;
  logic xfer, last;
  assign words_loaded = ptr;
  always_comb begin
    byte_ready = state inside {LEN_HI, LEN_LO, DATA};
    cpu_hold = state != DONE;
    done = state == DONE;
    error = state == ERR;
    xfer = byte_valid && byte_ready;
    last = xfer && state == DATA && cnt == 2'(WORD_BYTES - 1);
    n_new = {n[15:8], byte_in};
    nxt = state;
    case (state)
      LEN_HI: nxt = xfer ? LEN_LO : state;
      LEN_LO: nxt = !xfer ? state : n_new == 16'd0 ? DONE : n_new > 16'(DEPTH) ? ERR : DATA;
      DATA:   nxt = (last && 16'(ptr) + 16'd1 == n) ? DONE : state;
      default: nxt = start ? LEN_HI : state;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      n <= '0;
      ptr <= '0;
      cnt <= '0;
      asm_r <= '0;
    end else begin
      state <= nxt;
      if (xfer && state == LEN_HI) n[15:8] <= byte_in;
      if (xfer && state == LEN_LO) begin
        n[7:0] <= byte_in;
        ptr <= '0;
        cnt <= '0;
      end
      if (xfer && state == DATA) begin
        asm_r <= {asm_r[23:0], byte_in};
        cnt <= cnt + 2'd1;
      end
      if (last) ptr <= ptr + 1'b1;
    end
  imem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .reset(reset),
    .we(last),
    .waddr(ptr[$clog2(DEPTH)-1:0]),
    .wdata({asm_r[23:0], byte_in}),
    .addr(addr),
    .rdata(data)
  );
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for the instruction-memory loader.
module tb_imem_loader;
  logic clk = 0, reset = 1, start = 0, byte_valid = 0;
  logic [7:0] byte_in = 0;
  logic [31:0] addr = 0;
  logic byte_ready, cpu_hold, done, error;
  logic [31:0] data;
  logic [7:0] words_loaded;
  int errors = 0, checks = 0;
  logic [7:0] s1 [14] = '{8'h00, 8'h03, 8'h20, 8'h04, 8'h00, 8'h03, 8'h23, 8'hBD,
                          8'h01, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h04};

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .addr(addr), .data(data),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, data, exp);
  endtask

  task automatic put(input logic [7:0] b);
    int k;
    byte_in = b;
    byte_valid = 1;
    k = 0;
    while (!byte_ready && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL put_timeout got=ready0 exp=ready1");
    end else begin
      @(posedge clk);
      #1;
    end
    byte_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_hold", cpu_hold, 1);
    chk("rst_ready", byte_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_wl", words_loaded, 0);
    rd("rst_mem0", 0, 0);

    // Load N=3 with valid held high
    pulse_start();
    chk("t1_ready", byte_ready, 1);
    for (int i = 0; i < 13; i++) put(s1[i]);
    chk("t1_hold_pre", cpu_hold, 1);
    chk("t1_done_pre", done, 0);
    put(s1[13]);
    chk("t1_done", done, 1);
    chk("t1_hold", cpu_hold, 0);
    chk("t1_ready_done", byte_ready, 0);
    chk("t1_wl", words_loaded, 3);
    rd("t1_w0", 0, 32'h20040003);
    rd("t1_w1", 4, 32'h23BD0100);
    rd("t1_w2", 8, 32'h0C000004);
    rd("t1_w3", 12, 0);

    // Same stream with random gaps after a clearing reset
    do_reset();
    rd("t2_clr", 4, 0);
    pulse_start();
    for (int i = 0; i < 14; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      put(s1[i]);
    end
    chk("t2_done", done, 1);
    chk("t2_wl", words_loaded, 3);
    rd("t2_w0", 0, 32'h20040003);
    rd("t2_w1", 4, 32'h23BD0100);
    rd("t2_w2", 8, 32'h0C000004);

    // Oversized header -> ERR, memory untouched
    pulse_start();
    put(8'h00);
    put(8'h21);
    chk("t3_error", error, 1);
    chk("t3_hold", cpu_hold, 1);
    chk("t3_done", done, 0);
    chk("t3_ready", byte_ready, 0);
    rd("t3_w0", 0, 32'h20040003);
    pulse_start();
    chk("t3_error_clr", error, 0);
    chk("t3_ready_again", byte_ready, 1);

    // Zero-length load -> DONE
    put(8'h00);
    put(8'h00);
    chk("t4_done", done, 1);
    chk("t4_wl", words_loaded, 0);
    rd("t4_w2", 8, 32'h0C000004);

    // Reload N=1 with start pulsed during DATA
    pulse_start();
    put(8'h00);
    put(8'h01);
    put(8'hFF);
    pulse_start();
    chk("t5_ready_data", byte_ready, 1);
    chk("t5_hold_data", cpu_hold, 1);
    put(8'hFF);
    put(8'hFF);
    addr = 0;
    byte_in = 8'hFF;
    byte_valid = 1;
    #1;
    chk("t5_old_in_write_cycle", data, 32'h20040003);
    @(posedge clk);
    #1;
    byte_valid = 0;
    chk("t5_done", done, 1);
    chk("t5_wl", words_loaded, 1);
    rd("t5_w0", 0, 32'hFFFFFFFF);
    rd("t5_w1", 4, 32'h23BD0100);
    rd("t5_far", 32'h400, 0);
    rd("t5_oob", 32'h80, 0);

    // Reset after 6 data bytes
    pulse_start();
    put(8'h00);
    put(8'h03);
    for (int i = 2; i < 8; i++) put(s1[i]);
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    chk("t6_hold", cpu_hold, 1);
    chk("t6_ready", byte_ready, 0);
    chk("t6_done", done, 0);
    chk("t6_wl", words_loaded, 0);
    rd("t6_w0", 0, 0);
    rd("t6_w1", 4, 0);

    // Bytes offered while not ready are not consumed
    byte_in = 8'h77;
    byte_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    byte_valid = 0;
    pulse_start();
    put(8'h00);
    put(8'h01);
    put(8'hAB);
    put(8'hCD);
    put(8'hEF);
    put(8'h01);
    chk("t7_done", done, 1);
    rd("t7_w0", 0, 32'hABCDEF01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
